// File: rtl/io_handshake_unit_pkg.sv
// Shared definitions for the I/O instruction responder: FSM encoding and
// default widths used by io_handshake_unit and io_debouncer.
package io_handshake_unit_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned SW_W_DEF       = 10;
    localparam int unsigned DEB_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_DONE         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } io_state_e;

endpackage : io_handshake_unit_pkg

// File: rtl/io_debouncer.sv
// Confirm-button conditioning: 2-FF synchronizer, inversion, stable-count
// debounce and a one-cycle pulse on each debounced press.
module io_debouncer
    import io_handshake_unit_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_n,
    output logic btn_level,
    output logic press_pulse
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_sync;
    logic             btn_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic             toggle;

    assign btn_sync = ~sync_q[1];
    assign toggle   = (btn_sync != btn_q) && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, as the hardware does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Synchronizer clears to the released (high) pin level.
            sync_q  <= 2'b11;
            btn_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw_n};
            pulse_q <= toggle & ~btn_q;
            if (btn_sync == btn_q) begin
                cnt_q <= '0;
            end else if (toggle) begin
                btn_q <= ~btn_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign btn_level   = btn_q;
    assign press_pulse = pulse_q;

endmodule : io_debouncer

// File: rtl/io_handshake_unit.sv
// Responder for the core's IN/OUT instructions: stalls an IN until the
// operator confirms, captures the switches, and latches OUT data for display.
module io_handshake_unit
    import io_handshake_unit_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SW_W       = SW_W_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_req_in,
    input  logic              io_req_out,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SW_W-1:0]   switches,
    input  logic              confirm_n,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic [DATA_W-1:0] out_data,
    output logic              btn_pressed
);

    io_state_e       state_q, state_d;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    logic            press_pulse;
    logic            capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    io_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debouncer (
        .clk         (clk),
        .reset       (reset),
        .btn_raw_n   (confirm_n),
        .btn_level   (btn_pressed),
        .press_pulse (press_pulse)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (io_req_in) begin
                    stall = 1'b1;
                    // A button still held from earlier must be released first.
                    state_d = btn_pressed ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
                end
            end
            ST_WAIT_RELEASE: begin
                stall = 1'b1;
                if (!btn_pressed) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                stall = 1'b1;
                if (press_pulse) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rd_data  <= '0;
            out_data <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rd_data <= DATA_W'(sw_sync_q);
            end
            // Output instructions never stall and are accepted in any state.
            if (io_req_out) begin
                out_data <= wr_data;
            end
        end
    end

endmodule : io_handshake_unit

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit: scoreboard queues for captured read
// data and display writes, cycle-exact stall timing around the debounce.
module tb_io_handshake_unit;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SW_W       = 10;
    localparam int unsigned DEB_CYCLES = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              io_req_in = 1'b0;
    logic              io_req_out = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [SW_W-1:0]   switches = '0;
    logic              confirm_n = 1'b1;
    logic [DATA_W-1:0] rd_data;
    logic              stall;
    logic [DATA_W-1:0] out_data;
    logic              btn_pressed;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] out_q[$];

    io_handshake_unit #(
        .DATA_W     (DATA_W),
        .SW_W       (SW_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io_req_in   (io_req_in),
        .io_req_out  (io_req_out),
        .wr_data     (wr_data),
        .switches    (switches),
        .confirm_n   (confirm_n),
        .rd_data     (rd_data),
        .stall       (stall),
        .out_data    (out_data),
        .btn_pressed (btn_pressed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the DONE cycle (stall low), then score the captured value.
    task automatic wait_done(input string tag, input int budget);
        logic [DATA_W-1:0] exp;
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (stall !== 1'b0 && n < budget);
        check({tag, "_stall_fell"}, stall, 1'b0);
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 'x;
        check({tag, "_rd_data"}, rd_data, exp);
    endtask

    initial begin
        int bad;
        logic [DATA_W-1:0] exp;

        // Reset, then a quiet idle period with the button untouched.
        ticks(3);
        check("reset_stall", stall, 1'b0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_btn", btn_pressed, 1'b0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (stall !== 1'b0 || rd_data !== '0 || out_data !== '0 || btn_pressed !== 1'b0)
                bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        // Clean press: stall falls exactly 2 + DEB_CYCLES + 1 edges after the press.
        switches = 10'h2A5;
        ticks(3);
        rd_q.push_back(32'h0000_02A5);
        io_req_in = 1'b1;
        #1;
        check("clean_stall_same_cycle", stall, 1'b1);
        tick();
        io_req_in = 1'b0;
        #1;
        check("clean_wait_press_stall", stall, 1'b1);
        confirm_n = 1'b0;
        bad = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (stall !== 1'b1) bad++;
            if (k == 17) check("clean_btn_before_toggle", btn_pressed, 1'b0);
            if (k == 18) check("clean_btn_after_toggle", btn_pressed, 1'b1);
        end
        check("clean_stall_held_early", bad, 0);
        tick();
        check("clean_stall_fall_edge19", stall, 1'b0);
        exp = rd_q.pop_front();
        check("clean_rd_data", rd_data, exp);
        tick();
        check("clean_idle_after_done", stall, 1'b0);
        check("clean_rd_data_hold", rd_data, 32'h0000_02A5);

        confirm_n = 1'b1;
        ticks(25);
        check("clean_release", btn_pressed, 1'b0);

        // Bouncy press with the request held, as a frozen core would.
        switches = 10'h155;
        ticks(3);
        rd_q.push_back(32'h0000_0155);
        io_req_in = 1'b1;
        #1;
        check("bouncy_stall_req", stall, 1'b1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) confirm_n = ~confirm_n;
            tick();
            if (stall !== 1'b1) bad++;
        end
        check("bouncy_no_early_done", bad, 0);
        check("bouncy_btn_still_low", btn_pressed, 1'b0);
        confirm_n = 1'b0;
        wait_done("bouncy", 60);
        // Request still asserted one cycle later: DONE must already be over,
        // and the held button sends the new request to WAIT_RELEASE.
        tick();
        check("bouncy_done_one_cycle", stall, 1'b1);

        // Held button: no capture until release and a fresh press.
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (stall !== 1'b1) bad++;
        end
        check("held_stall_while_held", bad, 0);
        check("held_no_capture", rd_data, 32'h0000_0155);
        switches = 10'h3FF;
        confirm_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (stall !== 1'b1) bad++;
        end
        check("held_stall_after_release", bad, 0);
        check("held_btn_released", btn_pressed, 1'b0);

        // Output instruction while waiting for a press.
        wr_data = 32'hDEAD_BEEF;
        io_req_out = 1'b1;
        out_q.push_back(32'hDEAD_BEEF);
        tick();
        io_req_out = 1'b0;
        exp = out_q.pop_front();
        check("out_during_wait", out_data, exp);
        check("out_stall_unaffected", stall, 1'b1);
        check("out_rd_unaffected", rd_data, 32'h0000_0155);

        rd_q.push_back(32'h0000_03FF);
        confirm_n = 1'b0;
        wait_done("held", 60);
        io_req_in = 1'b0;
        tick();
        check("held_idle_after_done", stall, 1'b0);
        confirm_n = 1'b1;
        ticks(25);

        // Simultaneous IN and OUT, then reset in the middle of a debounce.
        wr_data = 32'h1234_5678;
        io_req_in = 1'b1;
        io_req_out = 1'b1;
        out_q.push_back(32'h1234_5678);
        #1;
        check("both_stall", stall, 1'b1);
        tick();
        io_req_in = 1'b0;
        io_req_out = 1'b0;
        exp = out_q.pop_front();
        check("both_out_data", out_data, exp);
        check("both_wait_press", stall, 1'b1);
        confirm_n = 1'b0;
        ticks(8);
        check("mid_debounce_stall", stall, 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_stall", stall, 1'b0);
        check("async_reset_rd_data", rd_data, 32'h0);
        check("async_reset_out_data", out_data, 32'h0);
        check("async_reset_btn", btn_pressed, 1'b0);
        ticks(2);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (stall !== 1'b0) bad++;
        end
        check("idle_press_ignored", bad, 0);
        check("idle_press_debounced", btn_pressed, 1'b1);
        check("idle_press_no_capture", rd_data, 32'h0);

        // The press seen in IDLE must not satisfy a later request.
        confirm_n = 1'b1;
        ticks(25);
        io_req_in = 1'b1;
        #1;
        check("not_queued_stall_req", stall, 1'b1);
        tick();
        io_req_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (stall !== 1'b1) bad++;
        end
        check("not_queued_stall_held", bad, 0);
        rd_q.push_back(32'h0000_03FF);
        confirm_n = 1'b0;
        wait_done("final", 60);
        tick();
        check("final_idle", stall, 1'b0);
        check("scoreboard_drained", rd_q.size() + out_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_io_handshake_unit

// File: doc/io_handshake_unit.md
Name: io_handshake_unit

Overview:
- Responder side of the processor's I/O instruction protocol.
- When the core issues an input instruction, the unit holds the core stalled until the operator presses the confirm button, then captures the switches, returns the value and releases the stall for exactly one cycle.
- Output instructions latch write data into a display register that drives the seven-segment decoders.
- Sits between the core (IO request/stall lines) and the board pins (switches, confirm button).

Parameters:
- DATA_W, 32, processor data width
- SW_W, 10, number of switches
- DEB_CYCLES, 16, consecutive stable samples required before the debounced button changes state (board build overrides to 500000)

Ports:
- clk  input  1  system clock (same clock as the core)
- reset  input  1  asynchronous active-low reset
- io_req_in  input  1  core executing an input instruction this cycle
- io_req_out  input  1  core executing an output instruction this cycle
- wr_data  input  DATA_W  value to display on output instruction
- switches  input  SW_W  raw board switches, asynchronous
- confirm_n  input  1  raw confirm button, active-low, asynchronous, bouncy
- rd_data  output  DATA_W  captured switch value, zero-extended, to core writeback mux
- stall  output  1  holds core PC and blocks register write while high
- out_data  output  DATA_W  display register, feeds hex decoders
- btn_pressed  output  1  debounced button level, for debug LED

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, stall=0, rd_data=0, out_data=0, btn_pressed=0, synchronizers and debounce counter cleared.
- Input synchronisation: confirm_n and switches each pass through a 2-FF synchronizer. The button is inverted after synchronisation.
- Debounce:
  - The counter increments while the synchronized level differs from btn_pressed; it clears when the levels match.
  - When the counter reaches DEB_CYCLES-1 and the levels still differ, btn_pressed toggles and the counter clears.
  - press_pulse is one cycle high on a 0->1 transition of btn_pressed.
- FSM states: IDLE, WAIT_PRESS, DONE, WAIT_RELEASE.
  - IDLE: if io_req_in, then stall=1 combinationally in the same cycle and next state is WAIT_PRESS. If io_req_in and btn_pressed=1 already, next state is WAIT_RELEASE instead. A held button never satisfies a new request.
  - WAIT_RELEASE: stall=1. When btn_pressed=0, go to WAIT_PRESS.
  - WAIT_PRESS: stall=1. On press_pulse, rd_data <= zero-extended synchronized switches and go to DONE.
  - DONE: stall=0 for exactly this one cycle. rd_data is stable and the core commits the write. Next state is IDLE.
  - Presses in IDLE are ignored and not queued.
- Latency: minimum from press edge on the pin to stall falling is 2 sync + DEB_CYCLES + 1 FSM cycles.
- rd_data holds its value until the next capture.
- Output path: io_req_out registers wr_data into out_data at the next edge. It never stalls and is accepted in any state.
- io_req_in and io_req_out together (not issued by the decoder, but defined): both actions proceed independently.
- io_req_in dropping while stalled (should not happen, since the PC is frozen): the FSM continues regardless. Capture completes and DONE still pulses.
- Reset mid-wait: immediate return to IDLE with stall=0. Any partial debounce is discarded.
- Switch changes during WAIT_PRESS have no effect. Only the value present at the press_pulse cycle is captured.

Decomposition:
- Shared package: FSM state encoding (2-bit: IDLE=0, WAIT_PRESS=1, DONE=2, WAIT_RELEASE=3) and the DATA_W/SW_W defaults.
- One sub-module is natural: io_debouncer (synchronizer + counter + press_pulse), parameterised by DEB_CYCLES. It replaces the ad hoc debounce at the top level.

Test Plan:
- Reset then idle, button untouched, 50 cycles -> stall=0, rd_data=0, out_data=0 throughout.
- switches=10'h2A5, io_req_in pulse, confirm_n held low (clean) for 40 cycles -> stall rises in the request cycle; falls for exactly one cycle at 2+16+1 cycles after the press; rd_data=32'h000002A5.
- Bouncy press: confirm_n toggles every 3 cycles for 30 cycles, then stays low -> exactly one capture, DONE visited once, stall low for exactly one cycle.
- Button already held when io_req_in arrives -> stall stays high through WAIT_RELEASE. No capture until release followed by a new press with switches=10'h3FF; then rd_data=32'h000003FF.
- io_req_out with wr_data=32'hDEADBEEF during WAIT_PRESS -> out_data=32'hDEADBEEF next cycle; stall stays 1; FSM unaffected.
- reset asserted in WAIT_PRESS mid-debounce -> stall=0 immediately (asynchronous). After release, the press is ignored because the FSM is in IDLE.
